// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arbiter_pkg;

  // Default MMIO LED word address (exact match, no masking).
  localparam logic [31:0] LED_ADDR_DEF = 32'h0000_1000;

  // Master identifiers: core data port and boot/debug loader.
  typedef enum logic {
    M_CORE = 1'b0,
    M_LOAD = 1'b1
  } master_id_e;

  // Tag that travels down the read-return pipeline.
  typedef struct packed {
    logic       vld;
    master_id_e id;
    logic       led;
  } rd_tag_t;

  // The other requester of the pair.
  function automatic master_id_e other_master(master_id_e id);
    return (id == M_CORE) ? M_LOAD : M_CORE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/grant/read-return bus between one requester and the arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a burst cap while both masters request.
module dmem_arbiter_rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk_50M,
  input  logic       sysrst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output master_id_e last_gnt
);

  localparam int            CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST);

  master_id_e    last_gnt_reg, last_gnt_next;
  logic [CW-1:0] burst_cnt_reg, burst_cnt_next;
  master_id_e    gnt_id;
  logic          any_gnt;
  logic          keep;

  // Arbitration state; m0 wins the first contended cycle after reset.
  always_ff @(posedge clk_50M or negedge sysrst_n) begin
    if (!sysrst_n) begin
      last_gnt_reg  <= M_LOAD;
      burst_cnt_reg <= '0;
    end else begin
      last_gnt_reg  <= last_gnt_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Grant decision and burst bookkeeping; a nonzero count means the last master was granted last cycle.
  always_comb begin
    gnt_id         = M_CORE;
    any_gnt        = 1'b0;
    gnt            = 2'b00;
    last_gnt_next  = last_gnt_reg;
    burst_cnt_next = '0;
    keep           = (burst_cnt_reg != '0) && (burst_cnt_reg < CAP);
    case (req)
      2'b01: begin gnt_id = M_CORE; any_gnt = 1'b1; end
      2'b10: begin gnt_id = M_LOAD; any_gnt = 1'b1; end
      2'b11: begin
        gnt_id  = keep ? last_gnt_reg : other_master(last_gnt_reg);
        any_gnt = 1'b1;
      end
      default: ;
    endcase
    if (any_gnt) begin
      gnt           = (gnt_id == M_LOAD) ? 2'b10 : 2'b01;
      last_gnt_next = gnt_id;
      if ((gnt_id == last_gnt_reg) && (burst_cnt_reg != '0))
        burst_cnt_next = (burst_cnt_reg < CAP) ? burst_cnt_reg + 1'b1 : burst_cnt_reg;
      else
        burst_cnt_next = CW'(1);
    end
  end

  assign last_gnt = last_gnt_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: request mux, LED MMIO register and fixed-latency read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter logic [AW-1:0] LED_ADDR  = AW'(LED_ADDR_DEF),
  parameter int            RD_LAT    = 1,
  parameter int            MAX_BURST = 4
) (
  input  logic           clk_50M,
  input  logic           sysrst_n,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_wdata,
  output logic [3:0]     ram_wren,
  input  logic [DW-1:0]  ram_rdata,
  output logic [7:0]     led
);

  logic [1:0]    req_vec, we_vec, gnt_vec, rvalid_vec;
  logic [3:0]    be_vec    [2];
  logic [AW-1:0] addr_vec  [2];
  logic [DW-1:0] wdata_vec [2];
  logic [DW-1:0] rdata_vec [2];
  master_id_e    last_gnt;

  logic          sel_idx, any_gnt, sel_we, hit_led;
  logic [3:0]    sel_be;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata, rd_data;
  rd_tag_t       tag_next, out_tag;
  rd_tag_t       pipe_reg [RD_LAT];
  logic [7:0]    led_reg;

  assign req_vec      = {m1.req, m0.req};
  assign we_vec       = {m1.we, m0.we};
  assign be_vec[0]    = m0.be;
  assign be_vec[1]    = m1.be;
  assign addr_vec[0]  = m0.addr;
  assign addr_vec[1]  = m1.addr;
  assign wdata_vec[0] = m0.wdata;
  assign wdata_vec[1] = m1.wdata;

  dmem_arbiter_rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk_50M  (clk_50M),
    .sysrst_n (sysrst_n),
    .req      (req_vec),
    .gnt      (gnt_vec),
    .last_gnt (last_gnt)
  );

  // Steer the granted master onto the RAM port; LED writes never reach the RAM.
  always_comb begin
    sel_idx   = gnt_vec[1];
    any_gnt   = |gnt_vec;
    sel_we    = we_vec[sel_idx];
    sel_be    = be_vec[sel_idx];
    sel_addr  = addr_vec[sel_idx];
    sel_wdata = wdata_vec[sel_idx];
    hit_led   = (sel_addr == LED_ADDR);
    ram_addr  = any_gnt ? sel_addr : '0;
    ram_wdata = any_gnt ? sel_wdata : '0;
    ram_wren  = (any_gnt && sel_we && !hit_led) ? sel_be : 4'b0000;
    tag_next.vld = any_gnt && !sel_we;
    tag_next.id  = sel_idx ? M_LOAD : M_CORE;
    tag_next.led = hit_led;
  end

  // LED register: only byte lane 0 of a write to the LED word updates it.
  always_ff @(posedge clk_50M or negedge sysrst_n) begin
    if (!sysrst_n)
      led_reg <= '0;
    else if (any_gnt && sel_we && hit_led && sel_be[0])
      led_reg <= sel_wdata[7:0];
  end

  // Read-tag shift register aligned to the RAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk_50M or negedge sysrst_n) begin
    if (!sysrst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= tag_next;
      for (int i = 1; i < RD_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign out_tag = pipe_reg[RD_LAT-1];
  assign rd_data = out_tag.led ? {{(DW-8){1'b0}}, led_reg} : ram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      assign rvalid_vec[gi] = out_tag.vld && (out_tag.id == ((gi == 1) ? M_LOAD : M_CORE));
      assign rdata_vec[gi]  = rvalid_vec[gi] ? rd_data : '0;
    end
  endgenerate

  assign m0.gnt    = gnt_vec[0];
  assign m1.gnt    = gnt_vec[1];
  assign m0.rvalid = rvalid_vec[0];
  assign m1.rvalid = rvalid_vec[1];
  assign m0.rdata  = rdata_vec[0];
  assign m1.rdata  = rdata_vec[1];
  assign led       = led_reg;

endmodule
